pe_row_ctx_sequencer: RTL and testbench

- Context sequencer that drives the `config_buffer` input of one PE row (LSU plus four PEs).
- Holds a small context RAM of full-row configuration words, loaded by the host/CBG side.
- On `start`, replays contexts 0..ctx_len-1 for a programmed number of iterations, one word per cycle, honouring a stall input.
- Then drives NOP words for a drain window so PE and LSU pipelines flush, and signals completion.

---
 rtl/pe_row_ctx_sequencer_pkg.sv | 23 ++
 rtl/pe_row_ctx_sequencer_if.sv | 37 +++
 rtl/pe_ctx_ram.sv | 24 ++
 rtl/pe_row_ctx_sequencer.sv | 149 ++++++++++++++
 tb/tb_pe_row_ctx_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pe_row_ctx_sequencer_pkg.sv
// Shared widths, the NOP word and the sequencer state encoding for the PE row
// context sequencer.
package pe_row_ctx_sequencer_pkg;

  localparam int PE_I_W   = 12;
  localparam int L_I_W    = 16;
  localparam int Config_W = L_I_W + 4 * PE_I_W;

  localparam logic [Config_W-1:0] CFG_NOP = '0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/pe_row_ctx_sequencer_if.sv
// Host-facing bundle of the context sequencer: RAM load port, launch/control
// inputs, and the configuration stream plus status towards the PE row.
interface pe_row_ctx_sequencer_if
  import pe_row_ctx_sequencer_pkg::*;
#(
  parameter int CFG_W  = Config_W,
  parameter int AW     = 4,
  parameter int ITER_W = 16
);
  // Flow control: a word on config_buffer is consumed on every RUN cycle where
  // stall is low; with stall high the whole stream (words, counters) freezes.
  logic              cfg_wr_en;
  logic [AW-1:0]     cfg_wr_addr;
  logic [CFG_W-1:0]  cfg_wr_data;
  logic              start;
  logic [AW:0]       ctx_len;
  logic [ITER_W-1:0] iter_num;
  logic              stall;
  logic              abort;
  logic [CFG_W-1:0]  config_buffer;
  logic              busy;
  logic              done;
  logic [AW-1:0]     ctx_idx;
  logic [ITER_W-1:0] iter_idx;
  logic              wr_err;
  state_t            state;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, start, ctx_len, iter_num, stall, abort,
    input  config_buffer, busy, done, ctx_idx, iter_idx, wr_err, state
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, start, ctx_len, iter_num, stall, abort,
    output config_buffer, busy, done, ctx_idx, iter_idx, wr_err, state
  );
endinterface

// File: rtl/pe_ctx_ram.sv
// Context storage: one synchronous write port and one combinational read port;
// a read of the slot being written returns the incoming data.
module pe_ctx_ram #(
  parameter int CFG_W = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [CFG_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [CFG_W-1:0] o_rdata
);

  logic [CFG_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/pe_row_ctx_sequencer.sv
// Replays the stored row contexts for a programmed number of iterations, then
// flushes the PE row with NOP words and pulses done.
module pe_row_ctx_sequencer
  import pe_row_ctx_sequencer_pkg::*;
#(
  parameter int CFG_W     = Config_W,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int ITER_W    = 16,
  parameter int DRAIN_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  pe_row_ctx_sequencer_if.slave bus
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t            r_state, w_state_nxt;
  logic [CFG_W-1:0]  r_cfg, w_cfg_nxt;
  logic [AW-1:0]     r_ctx_idx, w_ctx_nxt;
  logic [ITER_W-1:0] r_iter_idx, w_iter_nxt;
  logic [AW:0]       r_ctx_len, w_len_nxt;
  logic [ITER_W-1:0] r_iter_num, w_num_nxt;
  logic [DW-1:0]     r_drain, w_drain_nxt;
  logic              r_wr_err;

  logic              w_busy;
  logic              w_ram_we;
  logic [AW:0]       w_len_sat;
  logic              w_last_ctx;
  logic              w_last_iter;
  logic [AW-1:0]     w_ctx_inc;
  logic [AW-1:0]     w_rd_addr;
  logic [CFG_W-1:0]  w_rd_data;

  assign w_busy      = (r_state == RUN) || (r_state == DRAIN);
  assign w_ram_we    = bus.cfg_wr_en && !w_busy;
  assign w_len_sat   = (bus.ctx_len > LEN_MAX) ? LEN_MAX : bus.ctx_len;
  assign w_last_ctx  = ({1'b0, r_ctx_idx} == (r_ctx_len - (AW+1)'(1)));
  assign w_last_iter = (r_iter_idx == (r_iter_num - ITER_W'(1)));
  assign w_ctx_inc   = w_last_ctx ? '0 : (r_ctx_idx + AW'(1));
  // In IDLE the read port already points at slot 0 so the first word is ready at start.
  assign w_rd_addr   = (r_state == RUN) ? w_ctx_inc : '0;

  pe_ctx_ram #(
    .CFG_W (CFG_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (bus.cfg_wr_addr),
    .i_wdata (bus.cfg_wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_nxt   = r_cfg;
    w_ctx_nxt   = r_ctx_idx;
    w_iter_nxt  = r_iter_idx;
    w_len_nxt   = r_ctx_len;
    w_num_nxt   = r_iter_num;
    w_drain_nxt = r_drain;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_len_nxt   = w_len_sat;
          w_num_nxt   = bus.iter_num;
          w_ctx_nxt   = '0;
          w_iter_nxt  = '0;
          w_drain_nxt = '0;
          if ((w_len_sat == '0) || (bus.iter_num == '0)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
            w_cfg_nxt   = w_rd_data;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_cfg_nxt   = CFG_NOP;
          w_ctx_nxt   = '0;
          w_iter_nxt  = '0;
        end else if (!bus.stall) begin
          if (w_last_ctx && w_last_iter) begin
            w_state_nxt = DRAIN;
            w_cfg_nxt   = CFG_NOP;
            w_ctx_nxt   = '0;
            w_drain_nxt = '0;
          end else begin
            w_ctx_nxt = w_ctx_inc;
            w_cfg_nxt = w_rd_data;
            if (w_last_ctx) w_iter_nxt = r_iter_idx + ITER_W'(1);
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_cfg_nxt   = CFG_NOP;
          w_ctx_nxt   = '0;
          w_iter_nxt  = '0;
        end else if (!bus.stall) begin
          if (r_drain == DW'(DRAIN_CYC - 1)) w_state_nxt = DONE;
          else                               w_drain_nxt = r_drain + DW'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cfg      <= CFG_NOP;
      r_ctx_idx  <= '0;
      r_iter_idx <= '0;
      r_ctx_len  <= '0;
      r_iter_num <= '0;
      r_drain    <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg      <= w_cfg_nxt;
      r_ctx_idx  <= w_ctx_nxt;
      r_iter_idx <= w_iter_nxt;
      r_ctx_len  <= w_len_nxt;
      r_iter_num <= w_num_nxt;
      r_drain    <= w_drain_nxt;
      r_wr_err   <= bus.cfg_wr_en && w_busy;
    end
  end

  assign bus.config_buffer = r_cfg;
  assign bus.busy          = w_busy;
  assign bus.done          = (r_state == DONE);
  assign bus.ctx_idx       = r_ctx_idx;
  assign bus.iter_idx      = r_iter_idx;
  assign bus.wr_err        = r_wr_err;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_pe_row_ctx_sequencer.sv
// Directed bench for the PE row context sequencer: per-cycle expected stream
// of {wr_err, done, busy, config_buffer} kept in a queue and compared at negedge.
module tb_pe_row_ctx_sequencer;
  import pe_row_ctx_sequencer_pkg::*;

  localparam int CFG_W     = Config_W;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int ITER_W    = 16;
  localparam int DRAIN_CYC = 4;
  localparam int EW        = CFG_W + 3;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0]    exp_q[$];
  logic [CFG_W-1:0] mdl_ram [DEPTH];

  // clock / reset
  always #5 clk = ~clk;

  pe_row_ctx_sequencer_if #(.CFG_W(CFG_W), .AW(AW), .ITER_W(ITER_W)) bus ();

  pe_row_ctx_sequencer #(
    .CFG_W     (CFG_W),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .ITER_W    (ITER_W),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_addr = '0;
    bus.cfg_wr_data = '0;
    bus.start       = 1'b0;
    bus.ctx_len     = '0;
    bus.iter_num    = '0;
    bus.stall       = 1'b0;
    bus.abort       = 1'b0;
  endtask

  task automatic ram_write(input int addr, input logic [CFG_W-1:0] data);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = AW'(addr);
    bus.cfg_wr_data = data;
    @(negedge clk);
    bus.cfg_wr_en = 1'b0;
    mdl_ram[addr] = data;
    check($sformatf("idle_wr_err_slot%0d", addr), bus.wr_err, '0);
  endtask

  function automatic logic wr_bit(input int c, input int wc);
    return (wc != 0) && (c == wc + 1);
  endfunction

  // Launch a run from a negedge in IDLE and score every cycle until the bench
  // expects the block to be idle again.
  task automatic run_check(input int len, input int num, input int stall_lo, input int stall_hi,
                           input int wr_cyc, input int start_cyc, input int abort_cyc,
                           input bit wf, input logic [CFG_W-1:0] wf_data);
    logic [CFG_W-1:0] words[$];
    logic [EW-1:0]    item;
    int eff, idx, c;
    bit aborted;
    if (wf) mdl_ram[0] = wf_data;
    eff = (len > DEPTH) ? DEPTH : len;
    if (eff != 0 && num != 0) begin
      for (int i = 0; i < num; i++)
        for (int j = 0; j < eff; j++) words.push_back(mdl_ram[j]);
      for (int d = 0; d < DRAIN_CYC; d++) words.push_back(CFG_NOP);
    end
    exp_q.delete();
    idx = 0; c = 1; aborted = 1'b0;
    while (idx < words.size() && !aborted) begin
      if (abort_cyc != 0 && c > abort_cyc) aborted = 1'b1;
      else begin
        exp_q.push_back({wr_bit(c, wr_cyc), 1'b0, 1'b1, words[idx]});
        if (!((c >= stall_lo && c <= stall_hi) || c == abort_cyc)) idx++;
        c++;
      end
    end
    if (!aborted) begin
      exp_q.push_back({wr_bit(c, wr_cyc), 1'b1, 1'b0, CFG_NOP});
      c++;
    end
    exp_q.push_back({wr_bit(c, wr_cyc), 1'b0, 1'b0, CFG_NOP});
    c++;
    if (aborted) exp_q.push_back({wr_bit(c, wr_cyc), 1'b0, 1'b0, CFG_NOP});

    bus.start    = 1'b1;
    bus.ctx_len  = (AW+1)'(len);
    bus.iter_num = ITER_W'(num);
    if (wf) begin
      bus.cfg_wr_en   = 1'b1;
      bus.cfg_wr_addr = '0;
      bus.cfg_wr_data = wf_data;
    end
    c = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      c++;
      item = exp_q.pop_front();
      check($sformatf("L%0d_N%0d_cfg@%0d", len, num, c), bus.config_buffer, item[CFG_W-1:0]);
      check($sformatf("L%0d_N%0d_busy@%0d", len, num, c), bus.busy, item[CFG_W]);
      check($sformatf("L%0d_N%0d_done@%0d", len, num, c), bus.done, item[CFG_W+1]);
      check($sformatf("L%0d_N%0d_wr_err@%0d", len, num, c), bus.wr_err, item[CFG_W+2]);
      bus.start       = (c == start_cyc);
      bus.ctx_len     = (AW+1)'($urandom_range(0, 31));
      bus.iter_num    = ITER_W'($urandom_range(0, 7));
      bus.stall       = (c >= stall_lo && c <= stall_hi) || (c == abort_cyc);
      bus.abort       = (c == abort_cyc);
      bus.cfg_wr_en   = (c == wr_cyc);
      bus.cfg_wr_addr = AW'(1);
      bus.cfg_wr_data = ~mdl_ram[1];
    end
    idle_inputs();
  endtask

  initial begin
    logic [CFG_W-1:0] w;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_cfg", bus.config_buffer, CFG_NOP);
    check("rst_busy", bus.busy, '0);
    check("rst_done", bus.done, '0);
    check("rst_ctx_idx", bus.ctx_idx, '0);
    check("rst_iter_idx", bus.iter_idx, '0);
    check("rst_wr_err", bus.wr_err, '0);
    check("rst_state", bus.state, CFG_W'(ST_IDLE));
    rst = 1'b1;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) begin
      w = CFG_W'({$urandom, $urandom}) | CFG_W'(1);
      ram_write(a, w);
    end

    run_check(3, 2, 0, 0, 0, 0, 0, 1'b0, '0);   // basic A,B,C,A,B,C + drain
    run_check(3, 2, 2, 4, 0, 0, 0, 1'b0, '0);   // stall while B presented
    run_check(0, 5, 0, 0, 0, 0, 0, 1'b0, '0);   // zero length
    run_check(2, 0, 0, 0, 0, 0, 0, 1'b0, '0);   // zero iterations
    run_check(3, 2, 0, 0, 2, 3, 0, 1'b0, '0);   // busy write and extra start
    run_check(4, 3, 0, 0, 0, 0, 2, 1'b0, '0);   // abort on second word with stall
    check("abort_ctx_idx", bus.ctx_idx, '0);
    check("abort_iter_idx", bus.iter_idx, '0);
    check("abort_state", bus.state, CFG_W'(ST_IDLE));
    run_check(4, 1, 0, 0, 0, 0, 0, 1'b0, '0);   // fresh replay after abort
    w = CFG_W'({$urandom, $urandom}) | CFG_W'(2);
    run_check(2, 1, 0, 0, 0, 0, 0, 1'b1, w);    // write slot 0 together with start
    run_check(20, 1, 0, 0, 0, 0, 0, 1'b0, '0);  // length saturates to DEPTH

    // asynchronous reset in the middle of a run
    bus.start    = 1'b1;
    bus.ctx_len  = (AW+1)'(3);
    bus.iter_num = ITER_W'(2);
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_cfg0", bus.config_buffer, mdl_ram[0]);
    check("mid_busy", bus.busy, CFG_W'(1));
    @(negedge clk);
    check("mid_cfg1", bus.config_buffer, mdl_ram[1]);
    check("mid_ctx_idx", bus.ctx_idx, CFG_W'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_cfg", bus.config_buffer, CFG_NOP);
    check("arst_busy", bus.busy, '0);
    check("arst_ctx_idx", bus.ctx_idx, '0);
    check("arst_iter_idx", bus.iter_idx, '0);
    check("arst_done", bus.done, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_busy", bus.busy, '0);
      check("post_rst_cfg", bus.config_buffer, CFG_NOP);
      check("post_rst_state", bus.state, CFG_W'(ST_IDLE));
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
